// File: rtl/store_pkg.sv
// rtl/store_pkg.sv - shared types and widths for the store read-modify-write unit
package store_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_t;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT,
        WRITE,
        ERR
    } state_t;

endpackage

// File: rtl/byte_lane_merge.sv
// rtl/byte_lane_merge.sv - little-endian insertion of store data into the old memory word
module byte_lane_merge
    import store_pkg::*;
(
    input  logic [WORD_W-1:0] old_word,
    input  logic [WORD_W-1:0] wdata,
    input  size_t             size,
    input  logic [1:0]        offset,
    output logic [WORD_W-1:0] merged
);

    always_comb begin
        merged = old_word;
        case (size)
            SZ_BYTE: begin
                case (offset)
                    2'd0:    merged[7:0]   = wdata[7:0];
                    2'd1:    merged[15:8]  = wdata[7:0];
                    2'd2:    merged[23:16] = wdata[7:0];
                    default: merged[31:24] = wdata[7:0];
                endcase
            end
            SZ_HALF: begin
                if (offset[1]) merged[31:16] = wdata[15:0];
                else           merged[15:0]  = wdata[15:0];
            end
            default: merged = wdata;
        endcase
    end

endmodule

// File: rtl/store_rmw.sv
// rtl/store_rmw.sv - byte/half stores via read-modify-write, word stores written directly
module store_rmw
    import store_pkg::*;
#(
    parameter int RD_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [1:0]        req_size,
    output logic              done,
    output logic              err,
    output logic [31:0]       mem_addr,
    output logic              mem_re,
    input  logic [31:0]       mem_rd,
    output logic              mem_we,
    output logic [31:0]       mem_wd
);

    localparam logic [2:0] LAT = 3'(RD_LATENCY);

    state_t            state_q, state_d;
    logic [31:0]       addr_q, addr_d;
    logic [1:0]        off_q, off_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    size_t             size_q, size_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              re_q, re_d, we_q, we_d, done_q, done_d, err_q, err_d;
    logic [WORD_W-1:0] wd_q, wd_d;
    logic [WORD_W-1:0] merged;
    size_t             size_in;

    byte_lane_merge u_merge (
        .old_word (mem_rd),
        .wdata    (wdata_q),
        .size     (size_q),
        .offset   (off_q),
        .merged   (merged)
    );

    assign size_in   = size_t'(req_size);
    assign req_ready = (state_q == IDLE);
    assign mem_addr  = addr_q;
    assign mem_re    = re_q;
    assign mem_we    = we_q;
    assign mem_wd    = wd_q;
    assign done      = done_q;
    assign err       = err_q;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        off_d   = off_q;
        wdata_d = wdata_q;
        size_d  = size_q;
        cnt_d   = cnt_q;
        wd_d    = wd_q;
        re_d    = 1'b0;
        we_d    = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d  = {req_addr[31:2], 2'b00};
                    off_d   = req_addr[1:0];
                    wdata_d = req_wdata;
                    size_d  = size_in;
                    if (size_in == SZ_RSVD || (size_in == SZ_HALF && req_addr[0])) begin
                        state_d = ERR;
                        err_d   = 1'b1;
                    end else if (size_in == SZ_WORD) begin
                        state_d = WRITE;
                        we_d    = 1'b1;
                        done_d  = 1'b1;
                        wd_d    = req_wdata;
                    end else begin
                        state_d = READ;
                        re_d    = 1'b1;
                    end
                end
            end
            READ: begin
                state_d = WAIT;
                cnt_d   = 3'd1;
            end
            // cnt_q counts cycles since mem_re; read data is valid when it reaches LAT
            WAIT: begin
                if (cnt_q == LAT) begin
                    wd_d    = merged;
                    we_d    = 1'b1;
                    done_d  = 1'b1;
                    state_d = WRITE;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            off_q   <= '0;
            wdata_q <= '0;
            size_q  <= SZ_BYTE;
            cnt_q   <= '0;
            wd_q    <= '0;
            re_q    <= 1'b0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            off_q   <= off_d;
            wdata_q <= wdata_d;
            size_q  <= size_d;
            cnt_q   <= cnt_d;
            wd_q    <= wd_d;
            re_q    <= re_d;
            we_q    <= we_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_store_rmw.sv
// tb/tb_store_rmw.sv - scoreboard bench for store_rmw at read latencies 1 and 3
module tb_store_rmw;

    typedef struct packed {
        int          cyc;
        logic [31:0] addr;
        logic [31:0] data;
        logic        done;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rv1 = 1'b0, rv3 = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic [1:0]  req_size = '0;
    logic        rdy1, done1, err1, re1, we1;
    logic        rdy3, done3, err3, re3, we3;
    logic [31:0] maddr1, wd1, rd1, maddr3, wd3, rd3;
    logic [31:0] p1;
    logic [31:0] p3 [3];
    logic [31:0] mem_data = 32'h0;
    logic        sel3 = 1'b0;
    logic        o_rdy, o_re, o_we, o_done, o_err;
    logic [31:0] o_addr, o_wd;
    int          cyc = 0;
    int          n_asserts = 0, n_fail = 0;
    int          both_cnt = 0, stray_cnt = 0;
    wr_t         wlog[$], rlog[$], exp_q[$];
    int          elog[$];

    store_rmw #(.RD_LATENCY(1)) dut1 (
        .clk(clk), .reset(reset), .req_valid(rv1), .req_ready(rdy1),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .done(done1), .err(err1), .mem_addr(maddr1), .mem_re(re1),
        .mem_rd(rd1), .mem_we(we1), .mem_wd(wd1)
    );

    store_rmw #(.RD_LATENCY(3)) dut3 (
        .clk(clk), .reset(reset), .req_valid(rv3), .req_ready(rdy3),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .done(done3), .err(err3), .mem_addr(maddr3), .mem_re(re3),
        .mem_rd(rd3), .mem_we(we3), .mem_wd(wd3)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        p1    <= re1 ? mem_data : 32'hBAD0BAD0;
        p3[0] <= re3 ? mem_data : 32'hBAD0BAD0;
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end

    assign rd1    = p1;
    assign rd3    = p3[2];
    assign o_rdy  = sel3 ? rdy3 : rdy1;
    assign o_re   = sel3 ? re3 : re1;
    assign o_we   = sel3 ? we3 : we1;
    assign o_done = sel3 ? done3 : done1;
    assign o_err  = sel3 ? err3 : err1;
    assign o_addr = sel3 ? maddr3 : maddr1;
    assign o_wd   = sel3 ? wd3 : wd1;

    always @(negedge clk) begin
        if (o_we) wlog.push_back('{cyc, o_addr, o_wd, o_done});
        if (o_re) rlog.push_back('{cyc, o_addr, 32'h0, 1'b0});
        if (o_err) elog.push_back(cyc);
        if (o_done && !o_we) stray_cnt++;
        if ((done1 && err1) || (done3 && err3)) both_cnt++;
    end

    function automatic logic [31:0] exp_merge(input logic [31:0] old, input logic [31:0] d,
                                              input logic [1:0] sz, input logic [1:0] off);
        logic [31:0] m;
        int          sh;
        sh = (sz == 2'b00) ? 8 * int'(off) : 16 * int'(off[1]);
        m  = ((sz == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF) << sh;
        return (old & ~m) | ((d << sh) & m);
    endfunction

    task automatic clear_logs();
        wlog.delete();
        rlog.delete();
        elog.delete();
        exp_q.delete();
    endtask

    task automatic set_valid(input logic v);
        if (sel3) rv3 = v;
        else      rv1 = v;
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz, output int n);
        int w;
        @(negedge clk);
        req_addr = a; req_wdata = d; req_size = sz;
        set_valid(1'b1);
        w = 0;
        while (!o_rdy && w < 30) begin @(negedge clk); w++; end
        n = cyc;
        @(negedge clk);
        set_valid(1'b0);
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_asserts++;
        if ({rdy1, re1, we1, done1, err1, maddr1, wd1} !== {1'b1, 4'b0, 64'b0}) begin
            $display("FAIL reset_l1: got rdy=%b re=%b we=%b done=%b err=%b addr=%h wd=%h expected rdy=1 others 0",
                     rdy1, re1, we1, done1, err1, maddr1, wd1);
            n_fail++;
        end
        n_asserts++;
        if ({rdy3, re3, we3, done3, err3, maddr3, wd3} !== {1'b1, 4'b0, 64'b0}) begin
            $display("FAIL reset_l3: got rdy=%b re=%b we=%b done=%b err=%b addr=%h wd=%h expected rdy=1 others 0",
                     rdy3, re3, we3, done3, err3, maddr3, wd3);
            n_fail++;
        end
        reset = 1'b0;
    endtask

    task automatic test_word();
        int n;
        wr_t e, g;
        clear_logs(); sel3 = 1'b0;
        send(32'h0000_0010, 32'hDEADBEEF, 2'b10, n);
        exp_q.push_back('{n + 1, 32'h10, 32'hDEADBEEF, 1'b1});
        repeat (5) @(negedge clk);
        n_asserts++;
        if (rlog.size() !== 0) begin $display("FAIL word_no_re: got %0d reads expected 0", rlog.size()); n_fail++; end
        n_asserts++;
        if (wlog.size() !== 1) begin $display("FAIL word_we_count: got %0d expected 1", wlog.size()); n_fail++; end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (wlog.size() > 0) ? wlog.pop_front() : '0;
            n_asserts++;
            if (g !== e) begin
                $display("FAIL word_write: got cyc=%0d addr=%h wd=%h done=%b expected cyc=%0d addr=%h wd=%h done=%b",
                         g.cyc, g.addr, g.data, g.done, e.cyc, e.addr, e.data, e.done);
                n_fail++;
            end
        end
    endtask

    task automatic test_byte();
        int n;
        wr_t e, g;
        clear_logs(); sel3 = 1'b0;
        mem_data = 32'h11223344;
        send(32'h0000_0022, 32'h0000_00AB, 2'b00, n);
        exp_q.push_back('{n + 3, 32'h20, 32'h11AB3344, 1'b1});
        for (int k = 0; k < 4; k++) begin
            int m;
            logic [31:0] d;
            d = 32'hFFFF_FF00 | 32'(8'hA0 + k);
            send(32'h0000_0040 + 32'(k), d, 2'b00, m);
            exp_q.push_back('{m + 3, 32'h40, exp_merge(32'h11223344, d, 2'b00, 2'(k)), 1'b1});
            repeat (3) @(negedge clk);
        end
        repeat (2) @(negedge clk);
        n_asserts++;
        if (rlog.size() < 1 || rlog[0].cyc !== n + 1 || rlog[0].addr !== 32'h20) begin
            $display("FAIL byte_re: got reads=%0d first_cyc=%0d expected first_cyc=%0d addr=00000020",
                     rlog.size(), (rlog.size() > 0) ? rlog[0].cyc : -1, n + 1);
            n_fail++;
        end
        n_asserts++;
        if (wlog.size() !== 5) begin $display("FAIL byte_we_count: got %0d expected 5", wlog.size()); n_fail++; end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (wlog.size() > 0) ? wlog.pop_front() : '0;
            n_asserts++;
            if (g !== e) begin
                $display("FAIL byte_write: got cyc=%0d addr=%h wd=%h done=%b expected cyc=%0d addr=%h wd=%h done=%b",
                         g.cyc, g.addr, g.data, g.done, e.cyc, e.addr, e.data, e.done);
                n_fail++;
            end
        end
    endtask

    task automatic test_half(input logic use3);
        int n, m, lat;
        wr_t e, g;
        clear_logs(); sel3 = use3;
        lat = use3 ? 3 : 1;
        mem_data = 32'h55667788;
        send(32'h0000_0006, 32'h0000_CAFE, 2'b01, n);
        exp_q.push_back('{n + 2 + lat, 32'h4, 32'hCAFE7788, 1'b1});
        repeat (lat + 2) @(negedge clk);
        send(32'h0000_0008, 32'h1234_BEEF, 2'b01, m);
        exp_q.push_back('{m + 2 + lat, 32'h8, 32'h5566BEEF, 1'b1});
        repeat (lat + 3) @(negedge clk);
        n_asserts++;
        if (rlog.size() !== 2 || rlog[0].cyc !== n + 1) begin
            $display("FAIL half_re: got reads=%0d first_cyc=%0d expected 2 first_cyc=%0d",
                     rlog.size(), (rlog.size() > 0) ? rlog[0].cyc : -1, n + 1);
            n_fail++;
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (wlog.size() > 0) ? wlog.pop_front() : '0;
            n_asserts++;
            if (g !== e) begin
                $display("FAIL half_write_lat%0d: got cyc=%0d addr=%h wd=%h done=%b expected cyc=%0d addr=%h wd=%h done=%b",
                         lat, g.cyc, g.addr, g.data, g.done, e.cyc, e.addr, e.data, e.done);
                n_fail++;
            end
        end
        sel3 = 1'b0;
    endtask

    task automatic test_err();
        logic [31:0] addrs [2];
        logic [1:0]  sizes [2];
        addrs[0] = 32'h0000_0005; sizes[0] = 2'b01;
        addrs[1] = 32'h0000_0008; sizes[1] = 2'b11;
        sel3 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            int n;
            clear_logs();
            send(addrs[i], 32'h0000_1234, sizes[i], n);
            n_asserts++;
            if (o_rdy !== 1'b0) begin $display("FAIL err_ready_n1[%0d]: got %b expected 0", i, o_rdy); n_fail++; end
            @(negedge clk);
            n_asserts++;
            if (o_rdy !== 1'b1) begin $display("FAIL err_ready_n2[%0d]: got %b expected 1", i, o_rdy); n_fail++; end
            repeat (2) @(negedge clk);
            n_asserts++;
            if (elog.size() !== 1 || elog[0] !== n + 1) begin
                $display("FAIL err_pulse[%0d]: got count=%0d first=%0d expected count=1 at %0d",
                         i, elog.size(), (elog.size() > 0) ? elog[0] : -1, n + 1);
                n_fail++;
            end
            n_asserts++;
            if (rlog.size() + wlog.size() !== 0) begin
                $display("FAIL err_no_access[%0d]: got re=%0d we=%0d expected 0", i, rlog.size(), wlog.size());
                n_fail++;
            end
        end
    endtask

    task automatic test_reset_mid();
        int n;
        clear_logs(); sel3 = 1'b1;
        mem_data = 32'hA5A5A5A5;
        send(32'h0000_0021, 32'h0000_0099, 2'b00, n);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_asserts++;
        if ({o_rdy, o_re, o_we, o_done, o_err, o_addr, o_wd} !== {1'b1, 4'b0, 64'b0}) begin
            $display("FAIL reset_mid_outputs: got rdy=%b re=%b we=%b done=%b err=%b addr=%h wd=%h expected rdy=1 others 0",
                     o_rdy, o_re, o_we, o_done, o_err, o_addr, o_wd);
            n_fail++;
        end
        repeat (8) @(negedge clk);
        n_asserts++;
        if (wlog.size() !== 0) begin $display("FAIL reset_mid_no_we: got %0d writes expected 0", wlog.size()); n_fail++; end
        sel3 = 1'b0;
    endtask

    task automatic test_back_to_back();
        int n, m, w;
        wr_t e, g;
        clear_logs(); sel3 = 1'b0;
        mem_data = 32'h11223344;
        @(negedge clk);
        req_addr = 32'h0000_0021; req_wdata = 32'h0000_0077; req_size = 2'b00; rv1 = 1'b1;
        w = 0;
        while (!rdy1 && w < 30) begin @(negedge clk); w++; end
        n = cyc;
        exp_q.push_back('{n + 3, 32'h20, 32'h11227744, 1'b1});
        @(negedge clk);
        req_addr = 32'h0000_0030; req_wdata = 32'h0102_0304; req_size = 2'b10;
        w = 0;
        while (!rdy1 && w < 30) begin @(negedge clk); w++; end
        m = cyc;
        exp_q.push_back('{m + 1, 32'h30, 32'h0102_0304, 1'b1});
        @(negedge clk);
        rv1 = 1'b0;
        repeat (4) @(negedge clk);
        n_asserts++;
        if (m !== n + 4) begin $display("FAIL b2b_accept: got cycle %0d expected %0d", m, n + 4); n_fail++; end
        n_asserts++;
        if (wlog.size() !== 2) begin $display("FAIL b2b_we_count: got %0d expected 2", wlog.size()); n_fail++; end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (wlog.size() > 0) ? wlog.pop_front() : '0;
            n_asserts++;
            if (g !== e) begin
                $display("FAIL b2b_write: got cyc=%0d addr=%h wd=%h done=%b expected cyc=%0d addr=%h wd=%h done=%b",
                         g.cyc, g.addr, g.data, g.done, e.cyc, e.addr, e.data, e.done);
                n_fail++;
            end
        end
    endtask

    task automatic test_exclusive();
        n_asserts++;
        if (both_cnt !== 0) begin $display("FAIL done_err_overlap: got %0d expected 0", both_cnt); n_fail++; end
        n_asserts++;
        if (stray_cnt !== 0) begin $display("FAIL done_without_we: got %0d expected 0", stray_cnt); n_fail++; end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        test_reset();
        test_word();
        test_byte();
        test_half(1'b0);
        test_half(1'b1);
        test_err();
        test_reset_mid();
        test_back_to_back();
        test_exclusive();
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
